// File: rtl/ram_fill_pkg.sv
// Shared types and default widths for the RAM fill arbiter slice.
package ram_fill_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_t;

endpackage

// File: rtl/ram_fill_arbiter_fill_counter.sv
// Address / remaining-count / data registers for the fill engine.
// FILL_INCREMENT_EN: data advances by one after each granted write (address-stamp pattern).
module fill_counter
  import ram_fill_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [ADDR_WIDTH-1:0] load_len,
  input  logic [DATA_WIDTH-1:0] load_value,
  output logic [ADDR_WIDTH-1:0] cur_addr,
  output logic [DATA_WIDTH-1:0] cur_value,
  output logic [ADDR_WIDTH-1:0] remaining
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      cur_value <= '0;
      remaining <= '0;
    end else if (load) begin
      cur_addr  <= load_addr;
      cur_value <= load_value;
      remaining <= load_len;
    end else if (advance) begin
      // address wraps naturally at 2**ADDR_WIDTH
      cur_addr  <= cur_addr + 1'b1;
      remaining <= remaining - 1'b1;
`ifdef FILL_INCREMENT_EN
      cur_value <= cur_value + 1'b1;
`else
      cur_value <= cur_value;
`endif
    end
  end

endmodule

// File: rtl/ram_fill_arbiter.sv
// RAM data-port arbiter: CPU has absolute priority, the fill engine uses idle cycles only.
// Optional macro FILL_INCREMENT_EN (see fill_counter) selects an incrementing fill pattern.
module ram_fill_arbiter
  import ram_fill_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH        = DEF_ADDR_WIDTH,
  parameter int unsigned RAM_SCREEN_OFFSET = 0,
  parameter int unsigned SCREEN_WORDS      = 24
) (
  input  logic                  cpu_clk,
  input  logic                  resetN,
  input  logic                  start,
  input  logic                  use_default,
  input  logic [ADDR_WIDTH-1:0] fill_base,
  input  logic [ADDR_WIDTH-1:0] fill_len,
  input  logic [DATA_WIDTH-1:0] fill_value,
  input  logic                  cpu_we,
  input  logic                  cpu_re,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] remaining
);

  localparam logic [ADDR_WIDTH-1:0] DEF_BASE = ADDR_WIDTH'(RAM_SCREEN_OFFSET);
  localparam logic [ADDR_WIDTH-1:0] DEF_LEN  = ADDR_WIDTH'(SCREEN_WORDS);

  fill_state_t           state;
  logic                  grant_fill;
  logic                  load;
  logic                  last;
  logic [ADDR_WIDTH-1:0] sel_base;
  logic [ADDR_WIDTH-1:0] sel_len;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_value;

  assign sel_base   = use_default ? DEF_BASE : fill_base;
  assign sel_len    = use_default ? DEF_LEN  : fill_len;
  assign load       = (state == IDLE) && start;
  assign grant_fill = (state == FILL) && !cpu_we && !cpu_re;
  assign last       = (remaining == ADDR_WIDTH'(1));

  fill_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fill_counter (
    .clk        (cpu_clk),
    .rst_n      (resetN),
    .load       (load),
    .advance    (grant_fill),
    .load_addr  (sel_base),
    .load_len   (sel_len),
    .load_value (fill_value),
    .cur_addr   (cur_addr),
    .cur_value  (cur_value),
    .remaining  (remaining)
  );

  always_comb begin
    ram_we    = cpu_we;
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    if (grant_fill) begin
      ram_we    = 1'b1;
      ram_addr  = cur_addr;
      ram_wdata = cur_value;
    end
  end

  always_ff @(posedge cpu_clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (sel_len != '0) begin
              state <= FILL;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        FILL: begin
          if (grant_fill && last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
